lsu_align: RTL and testbench

Load/store alignment unit sitting directly upstream of the data memory. It accepts one load or store request at a time from the execute stage, checks natural alignment, and drives the doubleword-wide data memory. Sub-doubleword stores use a read-modify-write sequence. Load data is returned lane-extracted and sign- or zero-extended for writeback.

---
 rtl/lsu_align_if.sv | 32 +++
 rtl/lsu_align.sv | 162 ++++++++++++++++
 tb/tb_lsu_align.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_align_if.sv
// Request and data-memory bus of the load/store alignment unit.
// valid/ready: a request transfers on the rising edge where req_valid && req_ready; the requester holds all req_* fields stable until then.
interface lsu_align_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 64
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_load;
  logic                  req_store;
  logic [2:0]            funct3;
  logic [DATA_W-1:0]     addr;
  logic [DATA_W-1:0]     store_data;
  logic                  dm_MemRead;
  logic                  dm_MemWrite;
  logic [DM_ADDRESS-1:0] dm_a;
  logic [DATA_W-1:0]     dm_wd;
  logic [DATA_W-1:0]     dm_rd;
  logic                  resp_valid;
  logic                  resp_err;
  logic [DATA_W-1:0]     load_data;

  modport slave (
    input  req_valid, req_load, req_store, funct3, addr, store_data, dm_rd,
    output req_ready, dm_MemRead, dm_MemWrite, dm_a, dm_wd, resp_valid, resp_err, load_data
  );

  modport master (
    output req_valid, req_load, req_store, funct3, addr, store_data, dm_rd,
    input  req_ready, dm_MemRead, dm_MemWrite, dm_a, dm_wd, resp_valid, resp_err, load_data
  );
endinterface

// File: rtl/lsu_align.sv
// Load/store alignment unit: checks natural alignment, drives the doubleword memory,
// merges sub-doubleword stores by read-modify-write and extends load data.
module lsu_align #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  lsu_align_if.slave  bus,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RD = 2'd1, S_WR = 2'd2, S_RSP = 2'd3} state_t;

  state_t                r_state;
  logic                  r_is_load;
  logic [2:0]            r_funct3;
  logic [2:0]            r_off;
  logic [DATA_W-1:0]     r_store_data;
  logic                  r_ready;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic [DM_ADDRESS-1:0] r_dm_a;
  logic [DATA_W-1:0]     r_dm_wd;
  logic                  r_resp_valid;
  logic                  r_resp_err;
  logic [DATA_W-1:0]     r_load_data;

  logic                  w_misalign;
  logic                  w_err;
  logic [5:0]            w_shift;
  logic [DATA_W-1:0]     w_lane;
  logic [DATA_W-1:0]     w_ext;
  logic [DATA_W-1:0]     w_mask;
  logic [DATA_W-1:0]     w_mask_sh;
  logic [DATA_W-1:0]     w_merge;

  always_comb begin
    w_misalign = 1'b0;
    case (bus.funct3[1:0])
      2'b01:   w_misalign = bus.addr[0];
      2'b10:   w_misalign = |bus.addr[1:0];
      2'b11:   w_misalign = |bus.addr[2:0];
      default: w_misalign = 1'b0;
    endcase
    w_err = (bus.req_load == bus.req_store) || (bus.funct3 == 3'b111) ||
            (bus.req_store && bus.funct3[2]) || w_misalign;
  end

  // Lane extraction and store merge both work off the latched byte offset.
  assign w_shift = {r_off, 3'b000};
  assign w_lane  = bus.dm_rd >> w_shift;

  always_comb begin
    w_ext = w_lane;
    case (r_funct3)
      3'b000:  w_ext = {{56{w_lane[7]}},  w_lane[7:0]};
      3'b001:  w_ext = {{48{w_lane[15]}}, w_lane[15:0]};
      3'b010:  w_ext = {{32{w_lane[31]}}, w_lane[31:0]};
      3'b100:  w_ext = {56'd0, w_lane[7:0]};
      3'b101:  w_ext = {48'd0, w_lane[15:0]};
      3'b110:  w_ext = {32'd0, w_lane[31:0]};
      default: w_ext = w_lane;
    endcase
  end

  always_comb begin
    w_mask = '1;
    case (r_funct3[1:0])
      2'b00:   w_mask = 64'h0000_0000_0000_00FF;
      2'b01:   w_mask = 64'h0000_0000_0000_FFFF;
      2'b10:   w_mask = 64'h0000_0000_FFFF_FFFF;
      default: w_mask = '1;
    endcase
    w_mask_sh = w_mask << w_shift;
    w_merge   = (bus.dm_rd & ~w_mask_sh) | ((r_store_data << w_shift) & w_mask_sh);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_is_load    <= 1'b0;
      r_funct3     <= 3'd0;
      r_off        <= 3'd0;
      r_store_data <= '0;
      r_ready      <= 1'b1;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_dm_a       <= '0;
      r_dm_wd      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_load_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_ready      <= 1'b0;
            r_is_load    <= bus.req_load;
            r_funct3     <= bus.funct3;
            r_off        <= bus.addr[2:0];
            r_store_data <= bus.store_data;
            if (w_err) begin
              r_state      <= S_RSP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
            end else begin
              r_dm_a <= {bus.addr[DM_ADDRESS-1:3], 3'b000};
              if (bus.req_store && (bus.funct3 == 3'b011)) begin
                r_state     <= S_WR;
                r_mem_write <= 1'b1;
                r_dm_wd     <= bus.store_data;
              end else begin
                r_state    <= S_RD;
                r_mem_read <= 1'b1;
              end
            end
          end
        end
        S_RD: begin
          r_mem_read <= 1'b0;
          if (r_is_load) begin
            r_state      <= S_RSP;
            r_dm_a       <= '0;
            r_resp_valid <= 1'b1;
            r_load_data  <= w_ext;
          end else begin
            r_state     <= S_WR;
            r_mem_write <= 1'b1;
            r_dm_wd     <= w_merge;
          end
        end
        S_WR: begin
          r_state      <= S_RSP;
          r_mem_write  <= 1'b0;
          r_dm_a       <= '0;
          r_dm_wd      <= '0;
          r_resp_valid <= 1'b1;
        end
        S_RSP: begin
          r_state      <= S_IDLE;
          r_ready      <= 1'b1;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_load_data  <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready   = r_ready;
  assign bus.dm_MemRead  = r_mem_read;
  assign bus.dm_MemWrite = r_mem_write;
  assign bus.dm_a        = r_dm_a;
  assign bus.dm_wd       = r_dm_wd;
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_err    = r_resp_err;
  assign bus.load_data   = r_load_data;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align with a doubleword memory model behind the dm bus.
module tb_lsu_align;
  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  logic       mem_clr;
  logic [63:0] mem [0:63];

  lsu_align_if bus ();

  lsu_align u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.dm_rd = mem[bus.dm_a[8:3]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 64'd0;
    end else if (bus.dm_MemWrite) begin
      mem[bus.dm_a[8:3]] <= bus.dm_wd;
    end
  end

  int checks;
  int failures;

  int          op_lat;
  int          op_nrd;
  int          op_nwr;
  int          op_both;
  logic        op_err;
  logic [63:0] op_ld;
  logic [8:0]  op_wa;
  logic [63:0] op_wd;
  logic        op_rdy_in_rsp;
  logic        op_rdy_after;

  // driver: issue one request and record what the bus did until the response
  task automatic do_req(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] d);
    int n;
    op_lat = 0; op_nrd = 0; op_nwr = 0; op_both = 0; op_err = 1'b0;
    op_ld = '0; op_wa = '0; op_wd = '0; op_rdy_in_rsp = 1'b1; op_rdy_after = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_load = ld; bus.req_store = st;
    bus.funct3 = f3; bus.addr = a; bus.store_data = d;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_timeout req_ready=%b required=1", bus.req_ready);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0; bus.req_load = 1'b0; bus.req_store = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.dm_MemRead) op_nrd++;
      if (bus.dm_MemWrite) begin
        op_nwr++;
        op_wa = bus.dm_a;
        op_wd = bus.dm_wd;
      end
      if (bus.dm_MemRead && bus.dm_MemWrite) op_both++;
      if (bus.resp_valid) begin
        op_lat = c;
        op_err = bus.resp_err;
        op_ld = bus.load_data;
        op_rdy_in_rsp = bus.req_ready;
        break;
      end
    end
    checks++;
    if (op_lat == 0) begin
      failures++;
      $display("FAIL resp_timeout latency=none required=response within 10 cycles");
    end
    @(negedge clk);
    op_rdy_after = bus.req_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_clr = 1'b1;
    bus.req_valid = 1'b0; bus.req_load = 1'b0; bus.req_store = 1'b0;
    bus.funct3 = 3'd0; bus.addr = '0; bus.store_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; mem_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.req_ready); end
    checks++;
    if ({bus.dm_MemRead, bus.dm_MemWrite, bus.resp_valid, bus.resp_err} !== 4'b0 ||
        bus.dm_a !== 9'd0 || bus.dm_wd !== 64'd0 || bus.load_data !== 64'd0) begin
      failures++;
      $display("FAIL reset_outputs rd=%b wr=%b a=%h wd=%h rv=%b re=%b ld=%h exp=all zero",
               bus.dm_MemRead, bus.dm_MemWrite, bus.dm_a, bus.dm_wd, bus.resp_valid, bus.resp_err, bus.load_data);
    end
  endtask

  task automatic test_sd_ld();
    do_req(1'b0, 1'b1, 3'b011, 64'h10, 64'h1122334455667788);
    checks++;
    if (op_lat !== 2 || op_err !== 1'b0) begin failures++; $display("FAIL sd_resp lat=%0d err=%b exp lat=2 err=0", op_lat, op_err); end
    checks++;
    if (op_nwr !== 1 || op_nrd !== 0 || op_wa !== 9'h010 || op_wd !== 64'h1122334455667788) begin
      failures++;
      $display("FAIL sd_bus nwr=%0d nrd=%0d a=%h wd=%h exp nwr=1 nrd=0 a=010 wd=1122334455667788", op_nwr, op_nrd, op_wa, op_wd);
    end
    do_req(1'b1, 1'b0, 3'b011, 64'h10, 64'h0);
    checks++;
    if (op_lat !== 2 || op_ld !== 64'h1122334455667788 || op_nrd !== 1 || op_nwr !== 0) begin
      failures++;
      $display("FAIL ld_resp lat=%0d data=%h nrd=%0d nwr=%0d exp lat=2 data=1122334455667788 nrd=1 nwr=0", op_lat, op_ld, op_nrd, op_nwr);
    end
  endtask

  task automatic test_subword_merge();
    do_req(1'b0, 1'b1, 3'b000, 64'h13, 64'hFFFF_FFFF_FFFF_FFAB);
    checks++;
    if (op_lat !== 3 || op_nrd !== 1 || op_nwr !== 1 || op_both !== 0) begin
      failures++;
      $display("FAIL sb_seq lat=%0d nrd=%0d nwr=%0d both=%0d exp lat=3 nrd=1 nwr=1 both=0", op_lat, op_nrd, op_nwr, op_both);
    end
    checks++;
    if (op_wd !== 64'h11223344AB667788 || op_wa !== 9'h010) begin
      failures++;
      $display("FAIL sb_wd got a=%h wd=%h exp a=010 wd=11223344ab667788", op_wa, op_wd);
    end
    do_req(1'b1, 1'b0, 3'b011, 64'h10, 64'h0);
    checks++;
    if (op_ld !== 64'h11223344AB667788) begin failures++; $display("FAIL sb_readback got=%h exp=11223344ab667788", op_ld); end
    do_req(1'b0, 1'b1, 3'b010, 64'h14, 64'h0123_4567_DEAD_BEEF);
    checks++;
    if (op_lat !== 3 || op_wd !== 64'hDEADBEEFAB667788) begin
      failures++;
      $display("FAIL sw_wd lat=%0d wd=%h exp lat=3 wd=deadbeefab667788", op_lat, op_wd);
    end
    do_req(1'b0, 1'b1, 3'b001, 64'h16, 64'h0000_0000_0000_1234);
    checks++;
    if (op_wd !== 64'h1234BEEFAB667788) begin failures++; $display("FAIL sh_wd got=%h exp=1234beefab667788", op_wd); end
  endtask

  task automatic test_extension();
    do_req(1'b1, 1'b0, 3'b000, 64'h13, 64'h0);
    checks++;
    if (op_ld !== 64'hFFFFFFFFFFFFFFAB) begin failures++; $display("FAIL lb got=%h exp=ffffffffffffffab", op_ld); end
    do_req(1'b1, 1'b0, 3'b100, 64'h13, 64'h0);
    checks++;
    if (op_ld !== 64'h00000000000000AB) begin failures++; $display("FAIL lbu got=%h exp=00000000000000ab", op_ld); end
    do_req(1'b1, 1'b0, 3'b001, 64'h12, 64'h0);
    checks++;
    if (op_ld !== 64'hFFFFFFFFFFFFAB66) begin failures++; $display("FAIL lh got=%h exp=ffffffffffffab66", op_ld); end
    do_req(1'b1, 1'b0, 3'b101, 64'h12, 64'h0);
    checks++;
    if (op_ld !== 64'h000000000000AB66) begin failures++; $display("FAIL lhu got=%h exp=000000000000ab66", op_ld); end
    do_req(1'b1, 1'b0, 3'b010, 64'h14, 64'h0);
    checks++;
    if (op_ld !== 64'h000000001234BEEF) begin failures++; $display("FAIL lw_pos got=%h exp=000000001234beef", op_ld); end
    do_req(1'b1, 1'b0, 3'b010, 64'h10, 64'h0);
    checks++;
    if (op_ld !== 64'hFFFFFFFFAB667788) begin failures++; $display("FAIL lw_neg got=%h exp=ffffffffab667788", op_ld); end
    do_req(1'b1, 1'b0, 3'b110, 64'h10, 64'h0);
    checks++;
    if (op_ld !== 64'h00000000AB667788) begin failures++; $display("FAIL lwu got=%h exp=00000000ab667788", op_ld); end
  endtask

  task automatic test_misalign();
    do_req(1'b0, 1'b1, 3'b010, 64'h16, 64'h0000_0000_5A5A_5A5A);
    checks++;
    if (op_lat !== 1 || op_err !== 1'b1 || op_nrd !== 0 || op_nwr !== 0 || op_ld !== 64'd0) begin
      failures++;
      $display("FAIL sw_misalign lat=%0d err=%b nrd=%0d nwr=%0d ld=%h exp lat=1 err=1 no strobes ld=0", op_lat, op_err, op_nrd, op_nwr, op_ld);
    end
    do_req(1'b1, 1'b0, 3'b011, 64'h14, 64'h0);
    checks++;
    if (op_lat !== 1 || op_err !== 1'b1 || op_nrd !== 0 || op_nwr !== 0) begin
      failures++;
      $display("FAIL ld_misalign lat=%0d err=%b nrd=%0d nwr=%0d exp lat=1 err=1 no strobes", op_lat, op_err, op_nrd, op_nwr);
    end
    do_req(1'b1, 1'b0, 3'b001, 64'h11, 64'h0);
    checks++;
    if (op_lat !== 1 || op_err !== 1'b1) begin failures++; $display("FAIL lh_misalign lat=%0d err=%b exp lat=1 err=1", op_lat, op_err); end
    do_req(1'b1, 1'b0, 3'b011, 64'h10, 64'h0);
    checks++;
    if (op_ld !== 64'h1234BEEFAB667788 || op_err !== 1'b0) begin
      failures++;
      $display("FAIL misalign_mem_unchanged got=%h err=%b exp=1234beefab667788 err=0", op_ld, op_err);
    end
  endtask

  task automatic test_illegal();
    logic [2:0] f3_v [4]  = '{3'b100, 3'b011, 3'b111, 3'b011};
    logic       ld_v [4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic       st_v [4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 4; k++) begin
      do_req(ld_v[k], st_v[k], f3_v[k], 64'h10, 64'hFFFF_FFFF_FFFF_FFFF);
      checks++;
      if (op_lat !== 1 || op_err !== 1'b1 || op_nrd !== 0 || op_nwr !== 0) begin
        failures++;
        $display("FAIL illegal_%0d lat=%0d err=%b nrd=%0d nwr=%0d exp lat=1 err=1 no strobes", k, op_lat, op_err, op_nrd, op_nwr);
      end
    end
  endtask

  task automatic test_wrap();
    do_req(1'b0, 1'b1, 3'b011, 64'h0000_0001_0000_0208, 64'h0000_0000_0000_CAFE);
    checks++;
    if (op_wa !== 9'h008 || op_lat !== 2) begin failures++; $display("FAIL wrap_addr a=%h lat=%0d exp a=008 lat=2", op_wa, op_lat); end
    do_req(1'b1, 1'b0, 3'b011, 64'h8, 64'h0);
    checks++;
    if (op_ld !== 64'h000000000000CAFE) begin failures++; $display("FAIL wrap_readback got=%h exp=000000000000cafe", op_ld); end
  endtask

  task automatic test_back_to_back();
    do_req(1'b1, 1'b0, 3'b011, 64'h10, 64'h0);
    checks++;
    if (op_rdy_in_rsp !== 1'b0 || op_rdy_after !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready in_rsp=%b after=%b exp in_rsp=0 after=1", op_rdy_in_rsp, op_rdy_after);
    end
    do_req(1'b1, 1'b0, 3'b100, 64'h17, 64'h0);
    checks++;
    if (op_lat !== 2 || op_ld !== 64'h0000000000000012) begin
      failures++;
      $display("FAIL b2b_second lat=%0d data=%h exp lat=2 data=0000000000000012", op_lat, op_ld);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_load = 1'b0; bus.req_store = 1'b1;
    bus.funct3 = 3'b001; bus.addr = 64'h10; bus.store_data = 64'h5555;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0; bus.req_store = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.dm_MemRead !== 1'b1) begin failures++; $display("FAIL rstmid_rd got=%b exp=1", bus.dm_MemRead); end
    @(negedge clk);
    checks++;
    if (bus.dm_MemWrite !== 1'b1 || dbg_state !== 2'd2) begin
      failures++;
      $display("FAIL rstmid_wr wr=%b state=%0d exp wr=1 state=2", bus.dm_MemWrite, dbg_state);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.dm_MemWrite !== 1'b0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL rstmid_async wr=%b state=%0d exp wr=0 state=0", bus.dm_MemWrite, dbg_state);
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL rstmid_no_resp got=%b exp=0", bus.resp_valid); end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || {bus.dm_MemRead, bus.dm_MemWrite, bus.resp_valid, bus.resp_err} !== 4'b0 ||
        bus.dm_a !== 9'd0 || bus.dm_wd !== 64'd0 || bus.load_data !== 64'd0) begin
      failures++;
      $display("FAIL rstmid_release rdy=%b rd=%b wr=%b a=%h wd=%h rv=%b ld=%h exp rdy=1 others 0",
               bus.req_ready, bus.dm_MemRead, bus.dm_MemWrite, bus.dm_a, bus.dm_wd, bus.resp_valid, bus.load_data);
    end
    do_req(1'b1, 1'b0, 3'b011, 64'h10, 64'h0);
    checks++;
    if (op_ld !== 64'h1234BEEFAB667788) begin failures++; $display("FAIL rstmid_mem got=%h exp=1234beefab667788", op_ld); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_sd_ld();
    test_subword_merge();
    test_extension();
    test_misalign();
    test_illegal();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
